// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS program loader: FSM states, checksum seed
// and the checksum accumulation step.
package mips_loader_pkg;

  typedef enum logic [2:0] {HDR, DATA, CSUM, FILL, RUN, ERR} ldr_state_t;

  localparam logic [7:0] CSUM_INIT      = 8'h00;
  localparam int         BYTES_PER_WORD = 4;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/mips_word_assembler.sv
// Collects four stream bytes into one 32-bit instruction word, in either byte order.
// word/word_valid are presented in the same cycle the 4th byte is accepted.
module mips_word_assembler
  import mips_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_r;
  logic [23:0] sr_r;

  // byte counter and holding register for the first three bytes of a word
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt_r <= 2'd0;
      sr_r  <= 24'd0;
    end else if (byte_en) begin
      cnt_r <= cnt_r + 2'd1;
      if (BIG_ENDIAN) begin
        sr_r <= {sr_r[15:0], byte_in};
      end else begin
        sr_r <= {byte_in, sr_r[23:8]};
      end
    end else begin
      cnt_r <= cnt_r;
      sr_r  <= sr_r;
    end
  end

  // completed word includes the byte arriving this cycle
  always_comb begin
    word_valid = byte_en && (cnt_r == LAST_BYTE);
    if (BIG_ENDIAN) begin
      word = {sr_r, byte_in};
    end else begin
      word = {byte_in, sr_r};
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// Boot loader: receives [N][4N bytes][CSUM], writes instruction memory, zero-fills the
// rest and releases the core only after the image checksum verifies.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int WORDS      = 16,
  parameter int ADDR_W     = 4,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [BITS-1:0]   imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W + 1)'(WORDS - 1);
  localparam logic [ADDR_W:0] FULL_IDX  = (ADDR_W + 1)'(WORDS);
  localparam logic [7:0]      MAX_WORDS = 8'(WORDS);

  ldr_state_t      state_r;
  logic [ADDR_W:0] idx_r;
  logic [ADDR_W:0] n_r;
  logic [7:0]      csum_r;
  logic            take_s;
  logic            word_valid_s;
  logic [31:0]     word_s;

  // byte acceptance is a decode of the state, gated off while reset is asserted
  always_comb begin
    case (state_r)
      HDR, DATA, CSUM: rx_ready = rst;
      default:         rx_ready = 1'b0;
    endcase
    take_s = rx_valid && rx_ready;
  end

  mips_word_assembler #(.BIG_ENDIAN(BIG_ENDIAN)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_r == HDR),
    .byte_en   (take_s && (state_r == DATA)),
    .byte_in   (rx_data),
    .word      (word_s),
    .word_valid(word_valid_s)
  );

  // loader FSM with registered memory-write and status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= HDR;
      idx_r      <= '0;
      n_r        <= '0;
      csum_r     <= CSUM_INIT;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      core_hold  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state_r)
        HDR: begin
          if (take_s) begin
            csum_r <= csum_step(CSUM_INIT, rx_data);
            if ((rx_data >= 8'd1) && (rx_data <= MAX_WORDS)) begin
              n_r     <= rx_data[ADDR_W:0];
              idx_r   <= '0;
              state_r <= DATA;
            end else begin
              err     <= 1'b1;
              state_r <= ERR;
            end
          end
        end
        DATA: begin
          if (take_s) begin
            csum_r <= csum_step(csum_r, rx_data);
            if (word_valid_s) begin
              imem_we    <= 1'b1;
              imem_waddr <= idx_r[ADDR_W-1:0];
              imem_wdata <= BITS'(word_s);
              idx_r      <= idx_r + 1'b1;
              if ((idx_r + 1'b1) == n_r) begin
                state_r <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (take_s) begin
            if (rx_data != csum_r) begin
              err     <= 1'b1;
              state_r <= ERR;
            end else if (n_r == FULL_IDX) begin
              core_hold <= 1'b0;
              done      <= 1'b1;
              state_r   <= RUN;
            end else begin
              idx_r   <= n_r;
              state_r <= FILL;
            end
          end
        end
        FILL: begin
          imem_we    <= 1'b1;
          imem_waddr <= idx_r[ADDR_W-1:0];
          imem_wdata <= '0;
          idx_r      <= idx_r + 1'b1;
          if (idx_r == LAST_IDX) begin
            core_hold <= 1'b0;
            done      <= 1'b1;
            state_r   <= RUN;
          end
        end
        RUN: begin
          if (start) begin
            core_hold <= 1'b1;
            done      <= 1'b0;
            state_r   <= HDR;
          end
        end
        ERR: begin
          if (start) begin
            err     <= 1'b0;
            state_r <= HDR;
          end
        end
        default: begin
          core_hold <= 1'b1;
          done      <= 1'b0;
          err       <= 1'b1;
          state_r   <= ERR;
        end
      endcase
    end
  end

endmodule
